// File: rtl/fm_pkg.sv
// fm_pkg: shared mode/state types and default geometry for the column scheduler
package fm_pkg;
  localparam int DEF_SCAN_RATE = 32;
  localparam int DEF_NUM_ROWS = 64;
  localparam int DEF_RGB_RES = 9;
  typedef enum logic [1:0] {MODE_CYL, MODE_SPHERE, MODE_CUBE, MODE_BOIDS} mode_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} sched_state_t;
endpackage

// File: rtl/theta_change_detect.sv
// theta_change_detect: one-cycle pulse whenever dtheta differs from its value last cycle
module theta_change_detect #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] dtheta,
  output logic         change
);
  logic [W-1:0] old_q, old_d;
  always_comb old_d = dtheta;
  always_ff @(posedge clk) old_q <= old_d;
  assign change = !rst && dtheta != old_q;
endmodule

// File: rtl/column_scheduler.sv
// column_scheduler: walks column pairs of one rotational slice and hands each to the hub75 driver
module column_scheduler
  import fm_pkg::*;
#(
  parameter int ROTATIONAL_RES = 1024,
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int SCAN_RATE = DEF_SCAN_RATE,
  parameter int RGB_RES = DEF_RGB_RES,
  parameter int SRC_LAT = 1
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic [$clog2(ROTATIONAL_RES)-1:0]       dtheta,
  input  logic [1:0]                              mode_req,
  output logic [1:0]                              mode,
  output logic [$clog2(SCAN_RATE)-1:0]            col_index,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]   src_columns,
  output logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]   columns,
  output logic [$clog2(SCAN_RATE)-1:0]            col_num1,
  output logic [$clog2(SCAN_RATE):0]              col_num2,
  output logic                                    data_valid,
  input  logic                                    hub75_ready,
  output logic                                    slice_done,
  output logic [7:0]                              overrun_cnt
);
  localparam int CW = $clog2(SCAN_RATE);
  localparam int LW = $clog2(SRC_LAT + 1);
  sched_state_t state_q, state_d;
  mode_t mode_q, mode_d;
  logic [LW-1:0] lat_q, lat_d;
  logic start_q, start_d, restart_q, restart_d;
  logic [CW-1:0] col_index_d, col_num1_d;
  logic [CW:0] col_num2_d;
  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns_d;
  logic data_valid_d, slice_done_d, begin_slice, overrun, change, xfer, last;
  logic [7:0] overrun_d;
  theta_change_detect #(.W($clog2(ROTATIONAL_RES))) u_tcd (
    .clk(clk_in), .rst(rst_in), .dtheta(dtheta), .change(change)
  );
  assign mode = mode_q;
  assign xfer = data_valid && hub75_ready;
  assign last = col_index == CW'(SCAN_RATE - 1);
  always_comb begin
    state_d = state_q;
    lat_d = lat_q;
    start_d = start_q;
    restart_d = restart_q;
    mode_d = mode_q;
    col_index_d = col_index;
    columns_d = columns;
    col_num1_d = col_num1;
    col_num2_d = col_num2;
    data_valid_d = data_valid;
    slice_done_d = 1'b0;
    begin_slice = 1'b0;
    overrun = 1'b0;
    case (state_q)
      S_IDLE: begin
        begin_slice = start_q || change;
        start_d = 1'b0;
      end
      S_ISSUE:
        if (change) begin
          begin_slice = 1'b1;
          overrun = 1'b1;
        end else if (lat_q == LW'(SRC_LAT - 1)) begin
          columns_d = src_columns;
          col_num1_d = col_index;
          col_num2_d = {1'b0, col_index} + (CW + 1)'(SCAN_RATE);
          data_valid_d = 1'b1;
          state_d = S_HOLD;
        end else lat_d = lat_q + 1'b1;
      S_HOLD:
        if (xfer) begin
          data_valid_d = 1'b0;
          restart_d = 1'b0;
          // a theta change landing on the final transfer starts a fresh slice rather than aborting this one
          if (restart_q || (change && !last)) begin
            begin_slice = 1'b1;
            overrun = !restart_q;
          end else if (last) begin
            slice_done_d = 1'b1;
            start_d = change;
            state_d = S_IDLE;
          end else begin
            col_index_d = col_index + 1'b1;
            lat_d = '0;
            state_d = S_ISSUE;
          end
        end else if (change) begin
          restart_d = 1'b1;
          overrun = !restart_q;
        end
      default: state_d = S_IDLE;
    endcase
    if (begin_slice) begin
      col_index_d = '0;
      mode_d = mode_t'(mode_req);
      lat_d = '0;
      state_d = S_ISSUE;
    end
    overrun_d = overrun_cnt + 8'(overrun && overrun_cnt != 8'hFF);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      lat_q <= '0;
      start_q <= 1'b1;
      restart_q <= 1'b0;
      mode_q <= MODE_CYL;
      col_index <= '0;
      columns <= '0;
      col_num1 <= '0;
      col_num2 <= '0;
      data_valid <= 1'b0;
      slice_done <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state_q <= state_d;
      lat_q <= lat_d;
      start_q <= start_d;
      restart_q <= restart_d;
      mode_q <= mode_d;
      col_index <= col_index_d;
      columns <= columns_d;
      col_num1 <= col_num1_d;
      col_num2 <= col_num2_d;
      data_valid <= data_valid_d;
      slice_done <= slice_done_d;
      overrun_cnt <= overrun_d;
    end
  end
endmodule

// File: tb/tb_column_scheduler.sv
// tb_column_scheduler: directed/randomized checks of column_scheduler with SRC_LAT=1 and SRC_LAT=3 instances
module tb_column_scheduler;
  localparam int SCAN = 32, ROWS = 64, RGB = 9;
  typedef logic [1:0][ROWS-1:0][RGB-1:0] pair_t;
  logic clk = 0, rst = 1, hub_ready = 0, sel = 0;
  logic [9:0] dtheta = '0;
  logic [1:0] mode_req = '0;
  int salt = 0;
  pair_t src1, src3, cols1, cols3, s_cols;
  logic [1:0] mode1, mode3, s_mode, mode_p1, mode_p2;
  logic [4:0] ci1, ci3, cn1_1, cn1_3, s_cn1, s_ci, idx_p1, idx_p2;
  logic [5:0] cn2_1, cn2_3, s_cn2;
  logic dv1, dv3, s_dv, done1, done3, s_done;
  logic [7:0] ovr1, ovr3, s_ovr;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  function automatic pair_t pair_of(input int idx, input int m, input int s);
    pair_t p;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < ROWS; r++) p[c][r] = 9'(idx * 37 + r * 11 + c * 173 + m * 59 + s);
    return p;
  endfunction

  // frame sources: immediate for SRC_LAT=1, two-stage delayed for SRC_LAT=3
  always @(posedge clk) begin
    idx_p1 <= ci3;
    idx_p2 <= idx_p1;
    mode_p1 <= mode3;
    mode_p2 <= mode_p1;
  end
  always_comb src1 = pair_of(int'(ci1), int'(mode1), salt);
  always_comb src3 = pair_of(int'(idx_p2), int'(mode_p2), salt);

  column_scheduler dut1 (
    .clk_in(clk), .rst_in(rst), .dtheta(dtheta), .mode_req(mode_req), .mode(mode1),
    .col_index(ci1), .src_columns(src1), .columns(cols1), .col_num1(cn1_1), .col_num2(cn2_1),
    .data_valid(dv1), .hub75_ready(hub_ready), .slice_done(done1), .overrun_cnt(ovr1)
  );
  column_scheduler #(.SRC_LAT(3)) dut3 (
    .clk_in(clk), .rst_in(rst), .dtheta(dtheta), .mode_req(mode_req), .mode(mode3),
    .col_index(ci3), .src_columns(src3), .columns(cols3), .col_num1(cn1_3), .col_num2(cn2_3),
    .data_valid(dv3), .hub75_ready(hub_ready), .slice_done(done3), .overrun_cnt(ovr3)
  );

  assign s_cols = sel ? cols3 : cols1;
  assign s_mode = sel ? mode3 : mode1;
  assign s_cn1 = sel ? cn1_3 : cn1_1;
  assign s_ci = sel ? ci3 : ci1;
  assign s_cn2 = sel ? cn2_3 : cn2_1;
  assign s_dv = sel ? dv3 : dv1;
  assign s_done = sel ? done3 : done1;
  assign s_ovr = sel ? ovr3 : ovr1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tg, obs, exp);
    end
  endtask

  task automatic check_pair(input string tg, input pair_t obs, input pair_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h/%0h expected %0h/%0h", tg, obs[0][0], obs[1][ROWS-1], exp[0][0], exp[1][ROWS-1]);
    end
  endtask

  task automatic check_idle(input string tg);
    check({tg, "_dv"}, s_dv, 0);
    check({tg, "_cn1"}, s_cn1, 0);
    check({tg, "_cn2"}, s_cn2, 0);
    check({tg, "_mode"}, s_mode, 0);
    check({tg, "_ci"}, s_ci, 0);
    check({tg, "_done"}, s_done, 0);
    check({tg, "_ovr"}, s_ovr, 0);
    check_pair({tg, "_cols"}, s_cols, '0);
  endtask

  task automatic bump();
    dtheta = dtheta + 10'($urandom_range(1, 1000));
  endtask

  // wait for a beat, verify it and its hold behaviour, then accept it; chg 1 = theta change while held, 2 = on the transfer edge
  task automatic consume(input string tg, input int idx, input int m, input int stall, input int gap, input int chg);
    int w = 0;
    pair_t e;
    while (!s_dv && w < 20) begin
      tick();
      w++;
    end
    check({tg, "_gap"}, w, gap);
    e = pair_of(idx, m, salt);
    check({tg, "_cn1"}, s_cn1, idx);
    check({tg, "_cn2"}, s_cn2, idx + SCAN);
    check({tg, "_mode"}, s_mode, m);
    check_pair({tg, "_cols"}, s_cols, e);
    for (int i = 0; i < stall; i++) begin
      hub_ready = 0;
      salt = $urandom_range(0, 511);
      if (chg == 1 && i == 0) bump();
      tick();
      check({tg, "_hold_dv"}, s_dv, 1);
      check({tg, "_hold_cn1"}, s_cn1, idx);
      check_pair({tg, "_hold_cols"}, s_cols, e);
    end
    if (chg == 2) bump();
    hub_ready = 1;
    tick();
    check({tg, "_xfer_dv"}, s_dv, 0);
  endtask

  initial begin
    dtheta = 10'($urandom_range(0, 1023));
    salt = $urandom_range(0, 511);
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      check_idle("rst");
    end
    sel = 0;
    rst = 0;
    hub_ready = 1;
    for (int e = 1; e <= 75; e++) begin
      tick();
      check("t1_dv", s_dv, e >= 2 && e <= 64 && e % 2 == 0);
      check("t1_done", s_done, e == 65);
      if (s_dv) begin
        check("t1_cn1", s_cn1, (e - 2) / 2);
        check("t1_cn2", s_cn2, (e - 2) / 2 + SCAN);
        check_pair("t1_cols", s_cols, pair_of((e - 2) / 2, 0, salt));
      end
    end
    mode_req = 1;
    bump();
    for (int k = 0; k < SCAN; k++) begin
      if (k == 10) mode_req = 3;
      consume("t2", k, 1, k == 7 ? 5 : $urandom_range(0, 2), k == 0 ? 2 : 1, 0);
      check("t2_done", s_done, k == SCAN - 1);
    end
    check("t2_ovr", s_ovr, 0);
    tick();
    check("t2_pulse", s_done, 0);
    bump();
    for (int k = 0; k <= 12; k++) begin
      if (k == 12) mode_req = 2;
      consume("t3", k, 3, k == 12 ? 3 : $urandom_range(0, 2), k == 0 ? 2 : 1, k == 12 ? 1 : 0);
      check("t3_done", s_done, 0);
    end
    check("t3_ovr", s_ovr, 1);
    for (int k = 0; k < SCAN; k++) begin
      consume("t3r", k, 2, $urandom_range(0, 2), 1, k == SCAN - 1 ? 2 : 0);
      check("t3r_done", s_done, k == SCAN - 1);
    end
    check("t3r_ovr", s_ovr, 1);
    consume("t3n", 0, 2, 0, 2, 0);
    for (int n = 1; n <= 300; n++) begin
      mode_req = 2'($urandom_range(0, 3));
      bump();
      tick();
      check("ab_dv", s_dv, 0);
      check("ab_ovr", s_ovr, n + 1 > 255 ? 255 : n + 1);
      check("ab_mode", s_mode, mode_req);
    end
    for (int k = 0; k < 4; k++) consume("ab", k, mode_req, $urandom_range(0, 2), 1, 0);
    rst = 1;
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      check_idle("mid_rst");
    end
    sel = 0;
    rst = 0;
    mode_req = 1;
    for (int k = 0; k < SCAN; k++) begin
      consume("rs", k, 1, $urandom_range(0, 1), k == 0 ? 2 : 1, 0);
      check("rs_done", s_done, k == SCAN - 1);
    end
    rst = 1;
    tick();
    tick();
    sel = 1;
    check_idle("t5_rst");
    rst = 0;
    mode_req = 3;
    for (int k = 0; k < SCAN; k++) begin
      consume("t5", k, 3, 0, k == 0 ? 4 : 3, 0);
      check("t5_done", s_done, k == SCAN - 1);
    end
    bump();
    for (int k = 0; k < SCAN; k++) begin
      consume("t5b", k, 3, $urandom_range(0, 2), k == 0 ? 4 : 3, 0);
      check("t5b_done", s_done, k == SCAN - 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
